object_mover: RTL and testbench



---
 rtl/object_pkg.sv | 15 +
 rtl/collision_latch.sv | 29 ++
 rtl/object_mover.sv | 142 ++++++++++++++
 tb/tb_object_mover.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/object_pkg.sv
// rtl/object_pkg.sv - shared constants and state type for the object mover
package object_pkg;

  localparam int FIXED_POINT_MULTIPLIER = 64;
  localparam int FIXED_POINT_SHIFT      = 6;

  // Bit positions inside hitEdgeCode and the collision snapshot
  localparam int TOP    = 3;
  localparam int LEFT   = 2;
  localparam int BOTTOM = 1;
  localparam int RIGHT  = 0;

  typedef enum logic [1:0] {S_IDLE, S_VEL, S_POS} mover_state_t;

endpackage

// File: rtl/collision_latch.sv
// rtl/collision_latch.sv - accumulates edge hits over a frame, snapshots them at frame start
module collision_latch (
  input  logic       clk,
  input  logic       reset,
  input  logic       collision,
  input  logic [3:0] hit_edge_code,
  input  logic       take_snapshot,
  output logic [3:0] snapshot
);

  logic [3:0] flags;
  logic [3:0] merged;

  // A hit arriving with the snapshot request still belongs to the ending frame
  assign merged = flags | (collision ? hit_edge_code : 4'b0000);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags    <= 4'b0000;
      snapshot <= 4'b0000;
    end else if (take_snapshot) begin
      snapshot <= merged;
      flags    <= 4'b0000;
    end else begin
      flags    <= merged;
    end
  end

endmodule

// File: rtl/object_mover.sv
// rtl/object_mover.sv - per-frame velocity/position integrator feeding the drawing stage
module object_mover
  import object_pkg::*;
#(
  parameter int INITIAL_X       = 280,
  parameter int INITIAL_Y       = 185,
  parameter int INITIAL_X_SPEED = 0,
  parameter int INITIAL_Y_SPEED = 0,
  parameter int X_SPEED         = 64,
  parameter int JUMP_SPEED      = 320,
  parameter int GRAVITY         = 4,
  parameter int MAX_Y_SPEED     = 512,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               moveLeft,
  input  logic               moveRight,
  input  logic               jumpReq,
  input  logic               collision,
  input  logic [3:0]         hitEdgeCode,
  output logic signed [10:0] topLeftX,
  output logic signed [10:0] topLeftY,
  output logic               busy
);

  localparam int X_MAX = (SCREEN_WIDTH - OBJECT_WIDTH_X) * FIXED_POINT_MULTIPLIER;
  localparam int Y_MAX = (SCREEN_HEIGHT - OBJECT_HEIGHT_Y) * FIXED_POINT_MULTIPLIER;

  mover_state_t state, state_next;

  logic signed [31:0] pos_x, pos_y, x_speed, y_speed;
  logic signed [31:0] vel_x, vel_y;
  logic signed [31:0] new_x, new_y, clamp_vx, clamp_vy;
  logic [3:0]         snapshot;
  logic               take_snapshot;

  assign take_snapshot = (state == S_IDLE) && startOfFrame;

  collision_latch u_collision_latch (
    .clk           (clk),
    .reset         (reset),
    .collision     (collision),
    .hit_edge_code (hitEdgeCode),
    .take_snapshot (take_snapshot),
    .snapshot      (snapshot)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (startOfFrame && enable) state_next = S_VEL;
      S_VEL:   state_next = S_POS;
      S_POS:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == S_VEL) || (state == S_POS);
  end

  // Velocity stage: bounce, then jump, then steering, then saturating gravity
  always_comb begin
    vel_x = x_speed;
    vel_y = y_speed;
    if ((snapshot[TOP] && y_speed < 0) || (snapshot[BOTTOM] && y_speed > 0))
      vel_y = -y_speed;
    if ((snapshot[LEFT] && x_speed < 0) || (snapshot[RIGHT] && x_speed > 0))
      vel_x = -x_speed;
    if (jumpReq && snapshot[BOTTOM])
      vel_y = -JUMP_SPEED;
    if (moveLeft && moveRight)
      vel_x = 32'sd0;
    else if (moveLeft)
      vel_x = -X_SPEED;
    else if (moveRight)
      vel_x = X_SPEED;
    vel_y = vel_y + GRAVITY;
    if (vel_y > MAX_Y_SPEED)
      vel_y = MAX_Y_SPEED;
  end

  always_comb begin
    new_x    = pos_x + x_speed;
    new_y    = pos_y + y_speed;
    clamp_vx = x_speed;
    clamp_vy = y_speed;
    if (new_x < 0) begin
      new_x    = 32'sd0;
      clamp_vx = 32'sd0;
    end else if (new_x > X_MAX) begin
      new_x    = X_MAX;
      clamp_vx = 32'sd0;
    end
    if (new_y < 0) begin
      new_y    = 32'sd0;
      clamp_vy = 32'sd0;
    end else if (new_y > Y_MAX) begin
      new_y    = Y_MAX;
      clamp_vy = 32'sd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x    <= INITIAL_X * FIXED_POINT_MULTIPLIER;
      pos_y    <= INITIAL_Y * FIXED_POINT_MULTIPLIER;
      x_speed  <= INITIAL_X_SPEED;
      y_speed  <= INITIAL_Y_SPEED;
      topLeftX <= 11'(INITIAL_X);
      topLeftY <= 11'(INITIAL_Y);
    end else begin
      case (state)
        S_VEL: begin
          x_speed <= vel_x;
          y_speed <= vel_y;
        end
        S_POS: begin
          pos_x    <= new_x;
          pos_y    <= new_y;
          x_speed  <= clamp_vx;
          y_speed  <= clamp_vy;
          topLeftX <= 11'(new_x >>> FIXED_POINT_SHIFT);
          topLeftY <= 11'(new_y >>> FIXED_POINT_SHIFT);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_object_mover.sv
// tb/tb_object_mover.sv - directed self-checking bench for object_mover
module tb_object_mover;
  import object_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic               sof_a = 0, enable_a = 0, left_a = 0, right_a = 0, jump_a = 0, coll_a = 0;
  logic [3:0]         code_a = 4'b0000;
  logic signed [10:0] tlx_a, tly_a;
  logic               busy_a;

  logic               sof_b = 0, enable_b = 0, left_b = 0, right_b = 0, jump_b = 0, coll_b = 0;
  logic [3:0]         code_b = 4'b0000;
  logic signed [10:0] tlx_b, tly_b;
  logic               busy_b;

  int vectors = 0;
  int miscompares = 0;

  object_mover dut_a (
    .clk(clk), .reset(reset), .startOfFrame(sof_a), .enable(enable_a),
    .moveLeft(left_a), .moveRight(right_a), .jumpReq(jump_a),
    .collision(coll_a), .hitEdgeCode(code_a),
    .topLeftX(tlx_a), .topLeftY(tly_a), .busy(busy_a)
  );

  object_mover #(.INITIAL_X(600), .X_SPEED(640), .GRAVITY(0)) dut_b (
    .clk(clk), .reset(reset), .startOfFrame(sof_b), .enable(enable_b),
    .moveLeft(left_b), .moveRight(right_b), .jumpReq(jump_b),
    .collision(coll_b), .hitEdgeCode(code_b),
    .topLeftX(tlx_b), .topLeftY(tly_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame_a(input logic coll_at_sof, input logic [3:0] code);
    @(negedge clk);
    sof_a = 1; coll_a = coll_at_sof; code_a = code;
    @(negedge clk);
    sof_a = 0; coll_a = 0; code_a = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  task automatic mid_hit_a(input logic [3:0] code);
    @(negedge clk);
    coll_a = 1; code_a = code;
    @(negedge clk);
    coll_a = 0; code_a = 4'b0000;
  endtask

  initial begin
    // Asynchronous reset, observed before any rising clock edge
    #1 reset = 1;
    #1;
    chk("reset_x", tlx_a, 280);
    chk("reset_y", tly_a, 185);
    chk("reset_busy", busy_a, 0);
    chk("reset_x_b", tlx_b, 600);
    repeat (2) @(negedge clk);
    reset = 0;
    enable_a = 1;
    enable_b = 1;

    // First gravity frame with busy/latency checks
    @(negedge clk); sof_a = 1;
    @(negedge clk); sof_a = 0;
    chk("busy_vel", busy_a, 1);
    @(negedge clk);
    chk("busy_pos", busy_a, 1);
    @(negedge clk);
    chk("busy_idle", busy_a, 0);
    chk("gravity_speed1", dut_a.y_speed, 4);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 15; i++) frame_a(0, 4'b0000);
    chk("gravity_speed16", dut_a.y_speed, 64);
    chk("gravity_y16", tly_a, 193);
    chk("gravity_x16", tlx_a, 280);

    right_a = 1;
    for (int i = 0; i < 10; i++) frame_a(0, 4'b0000);
    chk("steer_right_x", tlx_a, 290);
    left_a = 1;
    frame_a(0, 4'b0000);
    chk("steer_both_x", tlx_a, 290);
    chk("steer_both_speed", dut_a.x_speed, 0);
    left_a = 0; right_a = 0;

    // Yspeed 108, posY 13352 at this point
    mid_hit_a(4'b0010);
    frame_a(0, 4'b0000);
    chk("bounce_speed", dut_a.y_speed, -104);
    chk("bounce_y", tly_a, 207);

    jump_a = 1;
    frame_a(1, 4'b0010);
    chk("jump_speed", dut_a.y_speed, -316);
    chk("jump_y", tly_a, 202);
    frame_a(0, 4'b0000);
    chk("nojump_speed", dut_a.y_speed, -312);
    chk("nojump_y", tly_a, 197);
    jump_a = 0;

    frame_a(1, 4'b1000);
    chk("top_bounce_sof_speed", dut_a.y_speed, 316);
    chk("top_bounce_sof_y", tly_a, 202);

    // Disabled frame discards the pending bottom hit
    enable_a = 0;
    mid_hit_a(4'b0010);
    @(negedge clk); sof_a = 1;
    @(negedge clk); sof_a = 0;
    chk("disabled_busy", busy_a, 0);
    repeat (3) @(negedge clk);
    chk("disabled_y", tly_a, 202);
    chk("disabled_speed", dut_a.y_speed, 316);
    enable_a = 1;
    frame_a(0, 4'b0000);
    chk("after_disable_speed", dut_a.y_speed, 320);
    chk("after_disable_y", tly_a, 207);

    // Right-edge clamp on the second instance
    right_b = 1;
    @(negedge clk); sof_b = 1;
    @(negedge clk); sof_b = 0;
    repeat (4) @(negedge clk);
    chk("clamp_x", tlx_b, 608);
    chk("clamp_speed", dut_b.x_speed, 0);
    right_b = 0; left_b = 1;

    // startOfFrame held into S_VEL must not start a second update
    @(negedge clk); sof_b = 1;
    @(negedge clk);
    chk("dbl_sof_busy", busy_b, 1);
    @(negedge clk); sof_b = 0;
    repeat (4) @(negedge clk);
    chk("dbl_sof_x", tlx_b, 598);
    chk("dbl_sof_idle", busy_b, 0);

    // Reset landing in S_POS
    @(negedge clk); sof_b = 1;
    @(negedge clk); sof_b = 0;
    @(negedge clk);
    chk("pos_state", dut_b.state, S_POS);
    #1 reset = 1;
    #1;
    chk("rst_pos_x", tlx_b, 600);
    chk("rst_pos_busy", busy_b, 0);
    chk("rst_pos_state", dut_b.state, S_IDLE);
    chk("rst_pos_y_a", tly_a, 185);
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("rst_release_x", tlx_b, 600);
    chk("rst_release_speed", dut_b.x_speed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
